// File: rtl/usb_crc_pkg.sv
// Shared CRC constants and receive-checker state encoding for the USB
// serial interface engine.
//   CRC5_*  : token/SOF CRC (reflected polynomial, shifted LSB first)
//   CRC16_* : data-packet CRC, reserved for the data-packet checker
//   state_e : usb_token_crc5_check FSM states
package usb_crc_pkg;

    localparam logic [4:0]  CRC5_INIT       = 5'h1F;
    localparam logic [4:0]  CRC5_POLY_REFL  = 5'h14;

    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    // Register value left after shifting a good packet including its CRC.
    localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

    typedef enum logic [2:0] {
        WAIT_B1  = 3'd0,
        SHIFT_B1 = 3'd1,
        WAIT_B2  = 3'd2,
        SHIFT_B2 = 3'd3,
        COMPARE  = 3'd4
    } state_e;

endpackage

// File: rtl/crc5_serial_step.sv
// One bit of the USB CRC5, reflected form. Shared by the receive checker and
// the transmit generator so both ends produce bit-identical register values.
// Ports:
//   crc_i [4:0]  current CRC register
//   bit_i        next bit on the wire
//   crc_o [4:0]  CRC register after absorbing bit_i
module crc5_serial_step
    import usb_crc_pkg::*;
(
    input  logic [4:0] crc_i,
    input  logic       bit_i,
    output logic [4:0] crc_o
);

    logic [4:0] shifted;

    assign shifted = {1'b0, crc_i[4:1]};
    assign crc_o   = (crc_i[0] ^ bit_i) ? (shifted ^ CRC5_POLY_REFL) : shifted;

endmodule

// File: rtl/usb_token_crc5_check.sv
// Receive-side CRC5 checker for USB token/SOF packets. Takes the two bytes
// following the PID, recovers the 11-bit token field and checks the 5-bit
// CRC carried in the top of byte 2, one bit per clock.
// Ports:
//   clk, rst        system clock, async active-high reset
//   rstCheck        synchronous clear back to the first-byte state
//   byteValid       dataIn carries a token byte (taken only while ready=1)
//   dataIn [7:0]    received byte, bit 0 first on the wire
//   ready           a byte can be accepted this cycle
//   checkDone       one-cycle pulse, result valid
//   crcOK           CRC matched; held until the next token starts
//   tokenField[10:0]{byte2[2:0], byte1}; held until the next token starts
//   overrun         one-cycle pulse, a byte arrived while busy and was dropped
//
// state    | meaning
// WAIT_B1  | idle, waiting for byte 1 (addr / frame low)
// SHIFT_B1 | folding the 8 bits of byte 1 into the CRC
// WAIT_B2  | waiting for byte 2 (field high bits + CRC)
// SHIFT_B2 | folding the 3 field bits of byte 2 into the CRC
// COMPARE  | compare received CRC with inverted register, pulse checkDone
module usb_token_crc5_check
    import usb_crc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rstCheck,
    input  logic        byteValid,
    input  logic [7:0]  dataIn,
    output logic        ready,
    output logic        checkDone,
    output logic        crcOK,
    output logic [10:0] tokenField,
    output logic        overrun
);

    state_e      state_q, state_d;
    logic [7:0]  d_q, d_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  crc_q, crc_d;
    logic [4:0]  rx_crc_q, rx_crc_d;
    logic        ok_q, ok_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic [10:0] tok_q, tok_d;
    logic [4:0]  crc_step;

    crc5_serial_step u_step (
        .crc_i (crc_q),
        .bit_i (d_q[0]),
        .crc_o (crc_step)
    );

    assign ready = (state_q == WAIT_B1) || (state_q == WAIT_B2);

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        rx_crc_d = rx_crc_q;
        ok_d     = ok_q;
        tok_d    = tok_q;
        done_d   = 1'b0;
        ovr_d    = byteValid & ~ready;

        if (rstCheck) begin
            // Clear wins over a byte arriving in the same cycle: no accept, no overrun.
            state_d  = WAIT_B1;
            d_d      = 8'h00;
            cnt_d    = 3'd0;
            crc_d    = CRC5_INIT;
            rx_crc_d = 5'h00;
            ok_d     = 1'b0;
            tok_d    = 11'h000;
            ovr_d    = 1'b0;
        end else begin
            case (state_q)
                WAIT_B1: begin
                    if (byteValid) begin
                        d_d        = dataIn;
                        tok_d[7:0] = dataIn;
                        crc_d      = CRC5_INIT;
                        ok_d       = 1'b0;
                        cnt_d      = 3'd7;
                        state_d    = SHIFT_B1;
                    end
                end
                SHIFT_B1: begin
                    crc_d = crc_step;
                    d_d   = {1'b0, d_q[7:1]};
                    if (cnt_q == 3'd0) state_d = WAIT_B2;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                WAIT_B2: begin
                    if (byteValid) begin
                        d_d         = {5'b00000, dataIn[2:0]};
                        tok_d[10:8] = dataIn[2:0];
                        rx_crc_d    = dataIn[7:3];
                        cnt_d       = 3'd2;
                        state_d     = SHIFT_B2;
                    end
                end
                SHIFT_B2: begin
                    crc_d = crc_step;
                    d_d   = {1'b0, d_q[7:1]};
                    if (cnt_q == 3'd0) state_d = COMPARE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                COMPARE: begin
                    // CRC is sent inverted, so a good packet matches the complement.
                    ok_d    = (rx_crc_q == ~crc_q);
                    done_d  = 1'b1;
                    state_d = WAIT_B1;
                end
                default: state_d = WAIT_B1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_B1;
            d_q      <= 8'h00;
            cnt_q    <= 3'd0;
            crc_q    <= CRC5_INIT;
            rx_crc_q <= 5'h00;
            ok_q     <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            tok_q    <= 11'h000;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            rx_crc_q <= rx_crc_d;
            ok_q     <= ok_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            tok_q    <= tok_d;
        end
    end

    assign checkDone  = done_q;
    assign crcOK      = ok_q;
    assign tokenField = tok_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_usb_token_crc5_check.sv
module tb_usb_token_crc5_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rstCheck = 1'b0;
    logic        byteValid = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic        ready;
    logic        checkDone;
    logic        crcOK;
    logic [10:0] tokenField;
    logic        overrun;

    usb_token_crc5_check dut (
        .clk        (clk),
        .rst        (rst),
        .rstCheck   (rstCheck),
        .byteValid  (byteValid),
        .dataIn     (dataIn),
        .ready      (ready),
        .checkDone  (checkDone),
        .crcOK      (crcOK),
        .tokenField (tokenField),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        ok;
        logic [10:0] tok;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int ovr_seen = 0;
    int ovr_exp  = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Textbook non-reflected CRC5 (x^5+x^2+1), MSB-first register, fed in wire
    // order. The wire carries the inverted register MSB first, so the field in
    // byte2[7:3] (first wire bit at [3]) is the bit-reversed complement.
    function automatic logic [4:0] ref_crc5(input logic [10:0] f);
        int c = 31;
        int fb;
        int r = 0;
        for (int i = 0; i < 11; i++) begin
            fb = ((c >> 4) & 1) ^ int'(f[i]);
            c  = (c << 1) & 31;
            if (fb != 0) c = c ^ 5;
        end
        c = (~c) & 31;
        for (int j = 0; j < 5; j++)
            if (((c >> j) & 1) != 0) r = r | (1 << (4 - j));
        return r[4:0];
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (overrun) ovr_seen++;
            if (checkDone) begin
                chk("done_single", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got checkDone=1 expected no result (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("crcOK", int'(crcOK), int'(e.ok));
                    chk("tokenField", int'(tokenField), int'(e.tok));
                end
            end
            prev_done = checkDone;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Caller sits at a negedge; returns at the first negedge where ready=1.
    task automatic wait_ready(input string name);
        int w = 0;
        while (!ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got ready=0 after %0d cycles expected ready=1", name, w);
        end
    endtask

    // Returns at the negedge after the accepting edge; t_acc = that edge.
    task automatic send_byte(input logic [7:0] b, output int t_acc);
        wait_ready("ready_timeout");
        byteValid = 1'b1;
        dataIn    = b;
        t_acc     = cyc + 1;
        @(negedge clk);
        byteValid = 1'b0;
        dataIn    = 8'($urandom);
        chk("ready_drop", int'(ready), 0);
    endtask

    task automatic push_exp(input logic ok, input logic [10:0] tok, input int t1);
        exp_t e;
        e.ok  = ok;
        e.tok = tok;
        e.cyc = t1 + 4;
        exp_q.push_back(e);
    endtask

    task automatic send_token(input logic [7:0] b1, input logic [7:0] b2,
                              input logic ok, input int gap);
        int t0;
        int t1;
        send_byte(b1, t0);
        wait_ready("b1_ready_timeout");
        chk("b1_ready_lat", cyc, t0 + 8);
        repeat (gap) @(negedge clk);
        send_byte(b2, t1);
        push_exp(ok, {b2[2:0], b1}, t1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        logic [10:0] f;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [15:0] w;
        int k;

        #3;
        chk("rst_ready", int'(ready), 1);
        chk("rst_checkDone", int'(checkDone), 0);
        chk("rst_crcOK", int'(crcOK), 0);
        chk("rst_tokenField", int'(tokenField), 0);
        chk("rst_overrun", int'(overrun), 0);
        #4 rst = 1'b0;
        @(negedge clk);

        // SETUP addr 0 endp 0, then CRC bit flipped
        send_token(8'h00, 8'h10, 1'b1, 0);
        send_token(8'h00, 8'h18, 1'b0, 0);

        // Byte arriving during SHIFT_B1 is dropped
        send_byte(8'h00, t0);
        repeat (2) @(negedge clk);
        byteValid = 1'b1;
        dataIn    = 8'hFF;
        @(negedge clk);
        byteValid = 1'b0;
        chk("overrun_pulse", int'(overrun), 1);
        ovr_exp++;
        @(negedge clk);
        chk("overrun_width", int'(overrun), 0);
        wait_ready("ovr_ready_timeout");
        chk("ovr_shift_lat", cyc, t0 + 8);
        send_byte(8'h10, t1);
        push_exp(1'b1, 11'h000, t1);

        // rstCheck mid-shift
        send_byte(8'h00, t0);
        repeat (3) @(negedge clk);
        rstCheck = 1'b1;
        @(negedge clk);
        rstCheck = 1'b0;
        chk("rstCheck_ready", int'(ready), 1);
        chk("rstCheck_crcOK", int'(crcOK), 0);
        send_token(8'h00, 8'h10, 1'b1, 1);

        // rstCheck together with byteValid, idle and busy
        wait_ready("rc_ready_timeout");
        rstCheck  = 1'b1;
        byteValid = 1'b1;
        dataIn    = 8'h5A;
        @(negedge clk);
        rstCheck  = 1'b0;
        byteValid = 1'b0;
        chk("rc_bv_ready", int'(ready), 1);
        chk("rc_bv_tok", int'(tokenField), 0);
        send_byte(8'h33, t0);
        rstCheck  = 1'b1;
        byteValid = 1'b1;
        @(negedge clk);
        rstCheck  = 1'b0;
        byteValid = 1'b0;
        chk("rc_busy_overrun", int'(overrun), 0);
        chk("rc_busy_ready", int'(ready), 1);

        // Async rst in SHIFT_B2
        send_token(8'h7E, {ref_crc5(11'h27E), 3'b010}, 1'b1, 0);
        send_byte(8'hA5, t0);
        wait_ready("ar_ready_timeout");
        send_byte(8'h03, t1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", int'(ready), 1);
        chk("arst_checkDone", int'(checkDone), 0);
        chk("arst_crcOK", int'(crcOK), 0);
        chk("arst_tokenField", int'(tokenField), 0);
        chk("arst_overrun", int'(overrun), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        send_token(8'h00, 8'h10, 1'b1, 0);

        // Random good tokens
        for (int i = 0; i < 1000; i++) begin
            f  = 11'($urandom);
            b1 = f[7:0];
            b2 = {ref_crc5(f), f[10:8]};
            repeat ($urandom_range(2, 0)) @(negedge clk);
            send_token(b1, b2, 1'b1, $urandom_range(3, 0));
        end

        // Single-bit corruptions
        for (int i = 0; i < 300; i++) begin
            f = 11'($urandom);
            w = {ref_crc5(f), f[10:8], f[7:0]};
            k = $urandom_range(15, 0);
            w = w ^ (16'h0001 << k);
            send_token(w[7:0], w[15:8], 1'b0, $urandom_range(2, 0));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        chk("overrun_count", ovr_seen, ovr_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
